// File: rtl/breakout_pkg.sv
// breakout_pkg: shared playfield geometry and ball FSM state type.
// Contents: MAX_X/MAX_Y playfield size, BAR_Y_T paddle top row, state_t {IDLE, MOVE, MISS}.
package breakout_pkg;
    localparam int MAX_X   = 640;
    localparam int MAX_Y   = 480;
    localparam int BAR_Y_T = 429;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, MISS = 2'd2} state_t;
endpackage

// File: rtl/ball_animate_if.sv
// ball_animate_if: frame tick, serve, raster and paddle inputs plus ball position/video/event outputs.
// Modports: master drives tick75hz, launch, pix_x/pix_y, bar_x_l/bar_x_r and observes the rest;
//           slave (ball_animate) drives ball_x/ball_y, ball_on, ball_rgb, hit, miss.
interface ball_animate_if;
    logic        tick75hz;
    logic        launch;
    logic [11:0] pix_x, pix_y;
    logic [11:0] bar_x_l, bar_x_r;
    logic [11:0] ball_x, ball_y;
    logic        ball_on;
    logic [23:0] ball_rgb;
    logic        hit, miss;
    modport master (
        output tick75hz, launch, pix_x, pix_y, bar_x_l, bar_x_r,
        input  ball_x, ball_y, ball_on, ball_rgb, hit, miss
    );
    modport slave (
        input  tick75hz, launch, pix_x, pix_y, bar_x_l, bar_x_r,
        output ball_x, ball_y, ball_on, ball_rgb, hit, miss
    );
endinterface

// File: rtl/ball_rom.sv
// ball_rom: 8x8 round-ball mask, one row per address; bit 7 is the leftmost pixel.
// Ports: row (in, 3) mask row index; bits (out, 8) mask row.
module ball_rom (
    input  logic [2:0] row,
    output logic [7:0] bits
);
    localparam logic [7:0] ROM [8] = '{
        8'b0011_1100, 8'b0111_1110, 8'b1111_1111, 8'b1111_1111,
        8'b1111_1111, 8'b1111_1111, 8'b0111_1110, 8'b0011_1100
    };
    assign bits = ROM[row];
endmodule

// File: rtl/ball_animate.sv
// ball_animate: bouncing ball FSM (IDLE park on paddle, MOVE with wall/paddle reflection, MISS hold-off).
// Ports: clk, reset_n (async active-low), bus (ball_animate_if.slave).
// Config: BALL_ROUND_EN defined -> round mask from ball_rom (BALL_SIZE must be 8); undefined -> square ball.
module ball_animate #(
    parameter int BALL_SIZE  = 8,
    parameter int BALL_V     = 2,
    parameter int MAX_X      = breakout_pkg::MAX_X,
    parameter int MAX_Y      = breakout_pkg::MAX_Y,
    parameter int BAR_Y_T    = breakout_pkg::BAR_Y_T,
    parameter int MISS_TICKS = 75
) (
    input logic           clk,
    input logic           reset_n,
    ball_animate_if.slave bus
);
    import breakout_pkg::*;

    localparam int CW = $clog2(MISS_TICKS + 1);
    localparam logic signed [12:0] VS = 13'(BALL_V);
    localparam logic signed [12:0] SS = 13'(BALL_SIZE);
    localparam logic [11:0] PARK_Y = 12'(BAR_Y_T - BALL_SIZE);
    localparam logic [11:0] RIGHT_X = 12'(MAX_X - BALL_SIZE);

    state_t          state;
    logic [11:0]     ball_x, ball_y;
    logic            vx_pos, vy_pos;
    logic [CW-1:0]   cnt;
    logic            hit, miss;
    logic signed [12:0] nx, ny;
    logic [12:0]     bar_mid;
    logic [11:0]     park_x;
    logic            wall_l, wall_r, wall_t, exit_b, bounce;
    logic            in_box, mask;

    // Next position uses a signed intermediate so walls can be detected before wrap.
    assign nx      = $signed({1'b0, ball_x}) + (vx_pos ? VS : -VS);
    assign ny      = $signed({1'b0, ball_y}) + (vy_pos ? VS : -VS);
    assign wall_l  = nx <= 0;
    assign wall_r  = nx + SS >= 13'(MAX_X);
    assign wall_t  = ny <= 0;
    assign exit_b  = ny >= 13'(MAX_Y);
    // Paddle: moving down, crossing the paddle top this tick, x-span overlapping the paddle.
    assign bounce  = vy_pos && (ny + SS >= 13'(BAR_Y_T))
                  && ({1'b0, ball_y} + 13'(BALL_SIZE) < 13'(BAR_Y_T + BALL_V + 1))
                  && ({1'b0, ball_x} + 13'(BALL_SIZE - 1) >= {1'b0, bus.bar_x_l})
                  && (ball_x <= bus.bar_x_r);
    assign bar_mid = ({1'b0, bus.bar_x_l} + {1'b0, bus.bar_x_r}) >> 1;
    assign park_x  = bar_mid[11:0] - 12'(BALL_SIZE / 2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ball_x <= 12'(MAX_X / 2 - BALL_SIZE / 2);
            ball_y <= PARK_Y;
            vx_pos <= 1'b1;
            vy_pos <= 1'b0;
            cnt    <= '0;
            hit    <= 1'b0;
            miss   <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (bus.tick75hz) begin
                if (state == MISS) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MISS_TICKS - 1)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        vx_pos <= 1'b1;
                        vy_pos <= 1'b0;
                    end
                end else if (state == IDLE && !bus.launch) begin
                    ball_x <= park_x;
                    ball_y <= PARK_Y;
                    vx_pos <= 1'b1;
                    vy_pos <= 1'b0;
                end else begin
                    // MOVE, or the launch tick out of IDLE (velocity already +V/-V).
                    state  <= exit_b ? MISS : MOVE;
                    ball_x <= wall_l ? '0 : wall_r ? RIGHT_X : nx[11:0];
                    vx_pos <= wall_l ? 1'b1 : wall_r ? 1'b0 : vx_pos;
                    ball_y <= wall_t ? '0 : bounce ? PARK_Y : ny[11:0];
                    vy_pos <= wall_t ? 1'b1 : bounce ? 1'b0 : vy_pos;
                    hit    <= bounce;
                    miss   <= exit_b;
                end
            end
        end
    end

    assign in_box = ({1'b0, bus.pix_x} >= {1'b0, ball_x}) && ({1'b0, bus.pix_x} < {1'b0, ball_x} + 13'(BALL_SIZE))
                 && ({1'b0, bus.pix_y} >= {1'b0, ball_y}) && ({1'b0, bus.pix_y} < {1'b0, ball_y} + 13'(BALL_SIZE));

`ifdef BALL_ROUND_EN
    logic [7:0] rom_bits;
    logic [2:0] dx, dy;
    if (BALL_SIZE != 8) begin : g_size_chk
        $error("BALL_ROUND_EN requires BALL_SIZE == 8");
    end
    assign dx = bus.pix_x[2:0] - ball_x[2:0];
    assign dy = bus.pix_y[2:0] - ball_y[2:0];
    ball_rom u_rom (.row(dy), .bits(rom_bits));
    assign mask = rom_bits[3'd7 - dx];
`else
    assign mask = 1'b1;
`endif

    assign bus.ball_x   = ball_x;
    assign bus.ball_y   = ball_y;
    assign bus.ball_on  = in_box && mask && (state != MISS);
    assign bus.ball_rgb = 24'hFFFFFF;
    assign bus.hit      = hit;
    assign bus.miss     = miss;
endmodule

// File: tb/tb_ball_animate.sv
// tb_ball_animate: directed self-checking bench for ball_animate (default square-ball build).
module tb_ball_animate;
    import breakout_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0, passed = 0;
    int   hit_seen = 0, miss_seen = 0;
    logic [11:0] px, py;
    logic        pvx, pvy;

    ball_animate_if bus();
    ball_animate dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        hit_seen  += int'(bus.hit);
        miss_seen += int'(bus.miss);
    end

    typedef struct { logic [11:0] x; logic [11:0] y; logic on; } pix_vec_t;
    typedef struct { logic [11:0] x; logic [11:0] ey; logic eh; } pad_vec_t;
    pix_vec_t pv[8];
    pad_vec_t dv[4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_tick();
        @(negedge clk) bus.tick75hz = 1'b1;
        @(negedge clk) bus.tick75hz = 1'b0;
    endtask

    task automatic step(input string n, input int ex, input int ey);
        do_tick();
        chk({n, "_x"}, int'(bus.ball_x), ex);
        chk({n, "_y"}, int'(bus.ball_y), ey);
    endtask

    // Puts the ball mid-flight at (px,py) with the given direction, bypassing the serve.
    task place();
        @(negedge clk);
        force dut.ball_x = px;
        force dut.ball_y = py;
        force dut.vx_pos = pvx;
        force dut.vy_pos = pvy;
        force dut.state  = MOVE;
        #1;
        release dut.ball_x;
        release dut.ball_y;
        release dut.vx_pos;
        release dut.vy_pos;
        release dut.state;
    endtask

    task automatic set_bar(input int l, input int r);
        bus.bar_x_l = 12'(l);
        bus.bar_x_r = 12'(r);
    endtask

    initial begin
        int h0, m0;
        pv = '{'{12'd296, 12'd421, 1'b1}, '{12'd303, 12'd428, 1'b1}, '{12'd304, 12'd421, 1'b0},
               '{12'd295, 12'd421, 1'b0}, '{12'd296, 12'd429, 1'b0}, '{12'd296, 12'd420, 1'b0},
               '{12'd300, 12'd425, 1'b1}, '{12'd0,   12'd0,   1'b0}};
        dv = '{'{12'd73, 12'd421, 1'b1}, '{12'd72, 12'd422, 1'b0},
               '{12'd199, 12'd421, 1'b1}, '{12'd200, 12'd422, 1'b0}};
        bus.tick75hz = 1'b0;
        bus.launch   = 1'b0;
        bus.pix_x    = '0;
        bus.pix_y    = '0;
        set_bar(240, 360);
        repeat (2) @(negedge clk);
        chk("rst_x", int'(bus.ball_x), 316);
        chk("rst_y", int'(bus.ball_y), 421);
        chk("rst_state", int'(dut.state), int'(IDLE));
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_miss", int'(bus.miss), 0);
        chk("rgb", int'(bus.ball_rgb), 32'hFFFFFF);
        reset_n = 1'b1;
        step("park", 296, 421);
        for (int i = 0; i < 8; i++) begin
            bus.pix_x = pv[i].x;
            bus.pix_y = pv[i].y;
            #1 chk($sformatf("on%0d", i), int'(bus.ball_on), int'(pv[i].on));
        end
        bus.launch = 1'b1;
        step("launch", 298, 419);
        bus.launch = 1'b0;
        chk("launch_state", int'(dut.state), int'(MOVE));
        step("fly", 300, 417);
        // Right wall from a natural serve parked at x=629.
        @(negedge clk) reset_n = 1'b0;
        set_bar(630, 636);
        @(negedge clk) reset_n = 1'b1;
        step("rpark", 629, 421);
        bus.launch = 1'b1;
        step("rlaunch", 631, 419);
        bus.launch = 1'b0;
        step("rwall", 632, 417);
        step("rwall_back", 630, 415);
        px = 12'd1; py = 12'd200; pvx = 1'b0; pvy = 1'b0; place();
        step("lwall", 0, 198);
        step("lwall_back", 2, 196);
        px = 12'd1; py = 12'd1; place();
        step("corner", 0, 0);
        step("corner_back", 2, 2);
        set_bar(80, 199);
        px = 12'd100; py = 12'd420; pvx = 1'b1; pvy = 1'b1; place();
        step("pad", 102, 421);
        chk("pad_hit", int'(bus.hit), 1);
        @(negedge clk) chk("pad_hit_end", int'(bus.hit), 0);
        step("pad_up", 104, 419);
        chk("pad_hit_once", int'(bus.hit), 0);
        for (int i = 0; i < 4; i++) begin
            px = dv[i].x; py = 12'd420; pvx = 1'b1; pvy = 1'b1; place();
            do_tick();
            chk($sformatf("ovl%0d_y", i), int'(bus.ball_y), int'(dv[i].ey));
            chk($sformatf("ovl%0d_hit", i), int'(bus.hit), int'(dv[i].eh));
        end
        set_bar(600, 639);
        px = 12'd631; py = 12'd420; place();
        step("wallpad", 632, 421);
        chk("wallpad_hit", int'(bus.hit), 1);
        step("wallpad_back", 630, 419);
        // Bottom exit and MISS hold-off with launch held high.
        px = 12'd10; py = 12'd474; place();
        m0 = miss_seen;
        step("fall1", 12, 476);
        step("fall2", 14, 478);
        chk("fall2_miss", int'(bus.miss), 0);
        do_tick();
        chk("miss_pulse", int'(bus.miss), 1);
        chk("miss_state", int'(dut.state), int'(MISS));
        bus.pix_x = bus.ball_x;
        bus.pix_y = bus.ball_y;
        #1 chk("miss_hidden", int'(bus.ball_on), 0);
        bus.launch = 1'b1;
        repeat (74) do_tick();
        chk("miss_hold", int'(dut.state), int'(MISS));
        do_tick();
        chk("miss_done", int'(dut.state), int'(IDLE));
        bus.launch = 1'b0;
        chk("miss_once", miss_seen - m0, 1);
        step("repark", 615, 421);
        // Asynchronous reset in the middle of a would-be paddle bounce.
        bus.launch = 1'b1;
        do_tick();
        bus.launch = 1'b0;
        set_bar(80, 199);
        px = 12'd100; py = 12'd420; pvx = 1'b1; pvy = 1'b1; place();
        h0 = hit_seen; m0 = miss_seen;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_x", int'(bus.ball_x), 316);
        chk("arst_y", int'(bus.ball_y), 421);
        chk("arst_state", int'(dut.state), int'(IDLE));
        do_tick();
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        chk("arst_no_hit", hit_seen - h0, 0);
        chk("arst_no_miss", miss_seen - m0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
